// File: rtl/demux_dispatcher.sv
// demux_dispatcher
//   Round-robin word dispatcher that feeds a 4-bit, 4-way demultiplexer.
//   Words arrive over a valid/ready handshake and are buffered in a DEPTH-word
//   FIFO. The head word is loaded into a registered output stage together with
//   a 2-bit channel select. The select rotates round-robin over the channels
//   enabled in ch_mask.
//
//   Optional feature: define DISPATCH_CNT_EN to add disp_cnt, an 8-bit wrapping
//   count of output transfers.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_data/valid   input word and its valid strobe
//   in_ready        FIFO not full
//   ch_mask         channel enables (bit0=A .. bit3=D)
//   out_data/sel    registered word and channel select to the demux
//   out_valid       output stage holds a dispatched word
//   out_ready       downstream consumes the word this cycle
//   level           FIFO occupancy
//   disp_cnt        (DISPATCH_CNT_EN only) count of out_valid && out_ready
module demux_dispatcher #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 ch_mask,
  output logic [3:0]                 out_data,
  output logic [1:0]                 out_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level
`ifdef DISPATCH_CNT_EN
  ,
  output logic [7:0]                 disp_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [3:0]    r_out_data;
  logic [1:0]    r_out_sel;
  logic          r_out_valid;
  logic [1:0]    r_last;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_load;
  logic [1:0]    w_grant;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_push   = in_valid && !w_full;
  assign w_load   = (!r_out_valid || out_ready) && !w_empty && (ch_mask != '0);

  assign in_ready  = !w_full;
  assign level     = r_level;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

  // First enabled channel searching last+1 .. last+4 (mod 4); the last step
  // wraps back to last itself, so a lone enabled channel is granted again.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    w_grant = r_last;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = r_last + 2'(i);
      if (!found && ch_mask[idx]) begin
        w_grant = idx;
        found   = 1'b1;
      end
    end
  end

  // Storage needs no reset: pointers and level reset, so stale words are
  // never read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_load})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_last      <= '1;
    end else if (w_load) begin
      r_out_data  <= r_mem[r_rd_ptr];
      r_out_sel   <= w_grant;
      r_out_valid <= 1'b1;
      r_last      <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef DISPATCH_CNT_EN
  logic [7:0] r_disp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_cnt <= '0;
    end else if (r_out_valid && out_ready) begin
      r_disp_cnt <= r_disp_cnt + 1'b1;
    end
  end

  assign disp_cnt = r_disp_cnt;
`endif

endmodule

// File: tb/tb_demux_dispatcher.sv
module tb_demux_dispatcher;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ch_mask;
  logic [3:0]    out_data;
  logic [1:0]    out_sel;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
`ifdef DISPATCH_CNT_EN
  logic [7:0]    disp_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  demux_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ch_mask   (ch_mask),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
`ifdef DISPATCH_CNT_EN
    ,
    .disp_cnt  (disp_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {out_valid, out_data, out_sel}
  function automatic logic [31:0] ov(input logic v, input logic [3:0] d, input logic [1:0] s);
    return {25'd0, v, d, s};
  endfunction

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; ch_mask = '0; out_ready = 1'b0;
    #1;
    check("rst_out",      {out_valid, out_data, out_sel}, 32'd0);
    check("rst_level",    level, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
`ifdef DISPATCH_CNT_EN
    check("rst_cnt",      disp_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All channels, streaming
    ch_mask = 4'hF; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'h1; tick();
    check("t1_latency",  out_valid, 32'd0);
    check("t1_level0",   level, 32'd1);
    in_data = 4'h2; tick(); check("t1_w1", {out_valid, out_data, out_sel}, ov(1, 4'h1, 2'd0));
    in_data = 4'h3; tick(); check("t1_w2", {out_valid, out_data, out_sel}, ov(1, 4'h2, 2'd1));
    in_data = 4'h4; tick(); check("t1_w3", {out_valid, out_data, out_sel}, ov(1, 4'h3, 2'd2));
    in_data = 4'h5; tick(); check("t1_w4", {out_valid, out_data, out_sel}, ov(1, 4'h4, 2'd3));
    check("t1_level_steady", level, 32'd1);
    in_valid = 1'b0; tick(); check("t1_w5", {out_valid, out_data, out_sel}, ov(1, 4'h5, 2'd0));
    check("t1_level_end", level, 32'd0);
    tick(); check("t1_idle", out_valid, 32'd0);

    // Sparse mask B,D
    ch_mask = 4'b1010;
    in_valid = 1'b1; in_data = 4'hA; tick();
    in_data = 4'hB; tick(); check("t2_w1", {out_valid, out_data, out_sel}, ov(1, 4'hA, 2'd1));
    in_data = 4'hC; tick(); check("t2_w2", {out_valid, out_data, out_sel}, ov(1, 4'hB, 2'd3));
    in_valid = 1'b0; tick(); check("t2_w3", {out_valid, out_data, out_sel}, ov(1, 4'hC, 2'd1));
    tick(); check("t2_idle", out_valid, 32'd0);

    // Backpressure to full, then drain
    ch_mask = 4'hF; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h6; tick(); check("t3_lvl1", level, 32'd1);
    in_data = 4'h7; tick(); check("t3_out", {out_valid, out_data, out_sel}, ov(1, 4'h6, 2'd2));
    check("t3_lvl1b", level, 32'd1);
    in_data = 4'h8; tick(); check("t3_lvl2", level, 32'd2);
    in_data = 4'h9; tick(); check("t3_lvl3", level, 32'd3);
    check("t3_ready_before_full", in_ready, 32'd1);
    in_data = 4'hA; tick(); check("t3_lvl4", level, 32'd4);
    check("t3_ready_full", in_ready, 32'd0);
    check("t3_held1", {out_valid, out_data, out_sel}, ov(1, 4'h6, 2'd2));
    in_data = 4'hB; tick(); check("t3_no_push_full", level, 32'd4);
    check("t3_held2", {out_valid, out_data, out_sel}, ov(1, 4'h6, 2'd2));
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); check("t3_d1", {out_valid, out_data, out_sel}, ov(1, 4'h7, 2'd3)); check("t3_dl1", level, 32'd3);
    check("t3_ready_again", in_ready, 32'd1);
    tick(); check("t3_d2", {out_valid, out_data, out_sel}, ov(1, 4'h8, 2'd0)); check("t3_dl2", level, 32'd2);
    tick(); check("t3_d3", {out_valid, out_data, out_sel}, ov(1, 4'h9, 2'd1)); check("t3_dl3", level, 32'd1);
    tick(); check("t3_d4", {out_valid, out_data, out_sel}, ov(1, 4'hA, 2'd2)); check("t3_dl4", level, 32'd0);
    tick(); check("t3_idle", out_valid, 32'd0);

    // Zero mask accumulates, then single channel C
    ch_mask = 4'h0;
    in_valid = 1'b1; in_data = 4'h1; tick();
    in_data = 4'h2; tick();
    in_data = 4'h3; tick();
    in_valid = 1'b0; tick();
    check("t4_no_valid", out_valid, 32'd0);
    check("t4_level3", level, 32'd3);
    ch_mask = 4'b0100;
    tick(); check("t4_w1", {out_valid, out_data, out_sel}, ov(1, 4'h1, 2'd2)); check("t4_l2", level, 32'd2);
    tick(); check("t4_w2", {out_valid, out_data, out_sel}, ov(1, 4'h2, 2'd2)); check("t4_l1", level, 32'd1);
    tick(); check("t4_w3", {out_valid, out_data, out_sel}, ov(1, 4'h3, 2'd2)); check("t4_l0", level, 32'd0);
    tick(); check("t4_idle", out_valid, 32'd0);

    // Mask change while a word is held
    ch_mask = 4'b0001; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'hD; tick();
    in_data = 4'hE; tick(); check("t5_load", {out_valid, out_data, out_sel}, ov(1, 4'hD, 2'd0));
    in_valid = 1'b0; ch_mask = 4'b1000;
    tick(); check("t5_held", {out_valid, out_data, out_sel}, ov(1, 4'hD, 2'd0));
    out_ready = 1'b1;
    tick(); check("t5_next", {out_valid, out_data, out_sel}, ov(1, 4'hE, 2'd3));
    tick(); check("t5_idle", out_valid, 32'd0);

    // Reset mid-stream with FIFO half full
    ch_mask = 4'hF; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h1; tick();
    in_data = 4'h2; tick();
    in_data = 4'h3; tick(); check("t6_pre_level", level, 32'd2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out",   {out_valid, out_data, out_sel}, 32'd0);
    check("t6_rst_level", level, 32'd0);
    check("t6_rst_ready", in_ready, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ch_mask = 4'b0110; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'h7; tick();
    in_valid = 1'b0; tick();
    check("t6_after_rst", {out_valid, out_data, out_sel}, ov(1, 4'h7, 2'd1));
    check("t6_level", level, 32'd0);

`ifdef DISPATCH_CNT_EN
    check("t7_cnt0", disp_cnt, 32'd0);
    tick(); check("t7_cnt1", disp_cnt, 32'd1);
    for (int i = 0; i < 255; i++) begin
      in_valid = 1'b1; in_data = 4'(i); tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && out_valid; i++) tick();
    check("t7_drained", out_valid, 32'd0);
    check("t7_wrap", disp_cnt, 32'd0);
    in_valid = 1'b1; in_data = 4'h3; tick();
    in_valid = 1'b0; tick(); tick();
    check("t7_after_wrap", disp_cnt, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
